// File: rtl/clause_sweep_controller_if.sv
// Handshake bundle between the clause sweep controller, the clause memory/checker pair
// and the downstream consumer of the sweep results.
interface clause_sweep_controller_if #(
  parameter int unsigned PAIR_AW = 2,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned CNT_W   = 4
);
  logic               in_start;
  logic [1:0]         in_satisfied_flag;
  logic [PAIR_AW-1:0] out_clause_pair_addr;
  logic               out_checker_enable;
  logic               out_busy;
  logic               out_done;
  logic               out_all_satisfied;
  logic [CNT_W-1:0]   out_unsat_count;
  logic               out_first_unsat_valid;
  logic [IDX_W-1:0]   out_first_unsat_index;

  modport master (
    input  in_start, in_satisfied_flag,
    output out_clause_pair_addr, out_checker_enable, out_busy, out_done,
           out_all_satisfied, out_unsat_count, out_first_unsat_valid, out_first_unsat_index
  );

  modport slave (
    output in_start, in_satisfied_flag,
    input  out_clause_pair_addr, out_checker_enable, out_busy, out_done,
           out_all_satisfied, out_unsat_count, out_first_unsat_valid, out_first_unsat_index
  );
endinterface

// File: rtl/clause_sweep_controller.sv
// Walks the clause memory one pair at a time, drives the two-clause checker and
// accumulates the unsatisfied count and lowest unsatisfied clause index for the sweep.
module clause_sweep_controller #(
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned PAIR_AW     = 2,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                        in_clk,
  input  logic                        in_reset,
  clause_sweep_controller_if.master   sweep
);
  localparam int unsigned        NUM_PAIRS = (NUM_CLAUSES + 1) / 2;
  localparam logic [PAIR_AW-1:0] LAST_K    = PAIR_AW'(NUM_PAIRS - 1);
  localparam bit                 ODD_TAIL  = (NUM_CLAUSES % 2) == 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CHECK, S_DONE} state_t;

  state_t             state, state_next;
  logic [PAIR_AW-1:0] pair_k;
  logic [CNT_W-1:0]   acc_count, cnt_next;
  logic               acc_fv, fv_next;
  logic [IDX_W-1:0]   acc_idx, idx_next;
  logic               res_all_sat, res_fv;
  logic [CNT_W-1:0]   res_count;
  logic [IDX_W-1:0]   res_idx;
  logic [1:0]         unsat;
  logic [IDX_W-1:0]   idx_even, idx_odd;
  logic               last_pair;

  assign last_pair = (pair_k == LAST_K);

  // Slot 2 of the final pair is a phantom clause when the clause count is odd.
  always_comb begin
    unsat    = ~sweep.in_satisfied_flag;
    if (ODD_TAIL && last_pair) unsat[1] = 1'b0;
    idx_even = IDX_W'({pair_k, 1'b0});
    idx_odd  = idx_even | IDX_W'(1);
    cnt_next = acc_count + CNT_W'(unsat[0]) + CNT_W'(unsat[1]);
    fv_next  = acc_fv | unsat[0] | unsat[1];
    idx_next = acc_idx;
    if (!acc_fv) begin
      if (unsat[0])      idx_next = idx_even;
      else if (unsat[1]) idx_next = idx_odd;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (sweep.in_start) state_next = S_FETCH;
      S_FETCH: state_next = S_CHECK;
      S_CHECK: state_next = last_pair ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state       <= S_IDLE;
      pair_k      <= '0;
      acc_count   <= '0;
      acc_fv      <= 1'b0;
      acc_idx     <= '0;
      res_all_sat <= 1'b0;
      res_count   <= '0;
      res_fv      <= 1'b0;
      res_idx     <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          pair_k <= '0;
          if (sweep.in_start) begin
            acc_count <= '0;
            acc_fv    <= 1'b0;
            acc_idx   <= '0;
          end
        end
        S_CHECK: begin
          acc_count <= cnt_next;
          acc_fv    <= fv_next;
          acc_idx   <= idx_next;
          // Results take the final pair's contribution directly so they are valid in DONE.
          if (last_pair) begin
            pair_k      <= '0;
            res_all_sat <= (cnt_next == '0);
            res_count   <= cnt_next;
            res_fv      <= fv_next;
            res_idx     <= idx_next;
          end else begin
            pair_k <= pair_k + PAIR_AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sweep.out_clause_pair_addr  = pair_k;
  assign sweep.out_checker_enable    = (state == S_CHECK);
  assign sweep.out_busy              = (state == S_FETCH) || (state == S_CHECK);
  assign sweep.out_done              = (state == S_DONE);
  assign sweep.out_all_satisfied     = res_all_sat;
  assign sweep.out_unsat_count       = res_count;
  assign sweep.out_first_unsat_valid = res_fv;
  assign sweep.out_first_unsat_index = res_idx;
endmodule

// File: tb/tb_clause_sweep_controller.sv
// Directed bench for clause_sweep_controller: an 8-clause instance and a 5-clause instance
// with an odd tail, each fed by a small flag table indexed by the pair address.
module tb_clause_sweep_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic [1:0] tab_a [4];
  logic [1:0] tab_b [4];
  int n_checks = 0;
  int n_errors = 0;
  int sel = 0;

  always #5 clk = ~clk;

  clause_sweep_controller_if #(.PAIR_AW(2), .IDX_W(3), .CNT_W(4)) a_if ();
  clause_sweep_controller_if #(.PAIR_AW(2), .IDX_W(3), .CNT_W(3)) b_if ();

  assign a_if.in_start = start_a;
  assign b_if.in_start = start_b;
  assign a_if.in_satisfied_flag = a_if.out_checker_enable ? tab_a[a_if.out_clause_pair_addr] : 2'b00;
  assign b_if.in_satisfied_flag = b_if.out_checker_enable ? tab_b[b_if.out_clause_pair_addr] : 2'b00;

  clause_sweep_controller #(.NUM_CLAUSES(8), .PAIR_AW(2), .IDX_W(3), .CNT_W(4)) dut_a (
    .in_clk(clk), .in_reset(rst), .sweep(a_if.master));
  clause_sweep_controller #(.NUM_CLAUSES(5), .PAIR_AW(2), .IDX_W(3), .CNT_W(3)) dut_b (
    .in_clk(clk), .in_reset(rst), .sweep(b_if.master));

  logic       mx_en, mx_busy, mx_done;
  logic [1:0] mx_addr;
  always_comb begin
    mx_en   = (sel == 0) ? a_if.out_checker_enable   : b_if.out_checker_enable;
    mx_busy = (sel == 0) ? a_if.out_busy             : b_if.out_busy;
    mx_done = (sel == 0) ? a_if.out_done             : b_if.out_done;
    mx_addr = (sel == 0) ? a_if.out_clause_pair_addr : b_if.out_clause_pair_addr;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Starts one sweep on the selected instance; cycle 1 is the cycle after the accepting edge.
  task automatic run_sweep(input int s, output int done_cycle, output logic [7:0] seq);
    bit found = 0;
    sel = s;
    seq = '0;
    done_cycle = -1;
    @(negedge clk);
    if (s == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("busy_c1", 32'(mx_busy), 1);
        check("enable_c1", 32'(mx_en), 0);
      end
      if (mx_en) seq = (seq << 2) | 8'(mx_addr);
      if (mx_done) begin
        found = 1;
        done_cycle = c;
        check("busy_in_done", 32'(mx_busy), 0);
      end
    end
    check("done_seen", 32'(found), 1);
  endtask

  task automatic check_results_a(input string tag, input logic all_sat, input logic [3:0] cnt,
                                 input logic fv, input logic [2:0] idx);
    check({tag, "_all_sat"}, 32'(a_if.out_all_satisfied), 32'(all_sat));
    check({tag, "_count"},   32'(a_if.out_unsat_count),   32'(cnt));
    check({tag, "_fvalid"},  32'(a_if.out_first_unsat_valid), 32'(fv));
    check({tag, "_index"},   32'(a_if.out_first_unsat_index), 32'(idx));
  endtask

  initial begin
    int dc;
    logic [7:0] seq;
    int done_hits;
    for (int i = 0; i < 4; i++) begin tab_a[i] = 2'b11; tab_b[i] = 2'b11; end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_addr", 32'(a_if.out_clause_pair_addr), 0);
    check("rst_enable", 32'(a_if.out_checker_enable), 0);
    check("rst_busy", 32'(a_if.out_busy), 0);
    check("rst_done", 32'(a_if.out_done), 0);
    check_results_a("rst", 1'b0, 4'd0, 1'b0, 3'd0);

    // All clauses satisfied
    run_sweep(0, dc, seq);
    check("t1_done_cycle", 32'(dc), 9);
    check("t1_addr_seq", 32'(seq), 32'h1b);
    check_results_a("t1", 1'b1, 4'd0, 1'b0, 3'd0);
    @(negedge clk);
    check("t1_done_pulse_width", 32'(a_if.out_done), 0);

    // Clause 2 and clauses 6,7 unsatisfied
    tab_a[0] = 2'b11; tab_a[1] = 2'b10; tab_a[2] = 2'b11; tab_a[3] = 2'b00;
    run_sweep(0, dc, seq);
    check("t2_done_cycle", 32'(dc), 9);
    check("t2_addr_seq", 32'(seq), 32'h1b);
    check_results_a("t2", 1'b0, 4'd3, 1'b1, 3'd2);

    // Odd clause count: slot 2 of the last pair is masked
    tab_b[0] = 2'b11; tab_b[1] = 2'b11; tab_b[2] = 2'b01;
    run_sweep(1, dc, seq);
    check("t3_done_cycle", 32'(dc), 7);
    check("t3_addr_seq", 32'(seq), 32'h06);
    check("t3_all_sat", 32'(b_if.out_all_satisfied), 1);
    check("t3_count", 32'(b_if.out_unsat_count), 0);
    check("t3_fvalid", 32'(b_if.out_first_unsat_valid), 0);
    tab_b[2] = 2'b00;
    run_sweep(1, dc, seq);
    check("t3b_count", 32'(b_if.out_unsat_count), 1);
    check("t3b_index", 32'(b_if.out_first_unsat_index), 4);
    check("t3b_all_sat", 32'(b_if.out_all_satisfied), 0);
    sel = 0;

    // Sweep A (clauses 3,7 unsat), then sweep B all satisfied: A's results hold until B's done
    tab_a[0] = 2'b11; tab_a[1] = 2'b01; tab_a[2] = 2'b11; tab_a[3] = 2'b01;
    run_sweep(0, dc, seq);
    check_results_a("t6a", 1'b0, 4'd2, 1'b1, 3'd3);
    for (int i = 0; i < 4; i++) tab_a[i] = 2'b11;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (5) @(negedge clk);
    check_results_a("t6_hold", 1'b0, 4'd2, 1'b1, 3'd3);
    repeat (4) @(negedge clk);
    check("t6b_done", 32'(a_if.out_done), 1);
    check_results_a("t6b", 1'b1, 4'd0, 1'b0, 3'd0);

    // Reset during pair 2 CHECK (cycle 6) aborts the sweep
    tab_a[0] = 2'b00;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_in_pair2", 32'({a_if.out_checker_enable, a_if.out_clause_pair_addr}), 32'h6);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t4_busy", 32'(a_if.out_busy), 0);
    check("t4_addr", 32'(a_if.out_clause_pair_addr), 0);
    check("t4_enable", 32'(a_if.out_checker_enable), 0);
    check_results_a("t4", 1'b0, 4'd0, 1'b0, 3'd0);
    done_hits = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a_if.out_done) done_hits++;
    end
    check("t4_no_done", 32'(done_hits), 0);
    run_sweep(0, dc, seq);
    check("t4_restart_cycle", 32'(dc), 9);
    check_results_a("t4_restart", 1'b0, 4'd2, 1'b1, 3'd0);

    // Start held high: back-to-back sweeps every 10 cycles, no double counting
    tab_a[0] = 2'b11; tab_a[1] = 2'b10; tab_a[2] = 2'b11; tab_a[3] = 2'b00;
    @(negedge clk);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    done_hits = 0;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      if (a_if.out_done) begin
        done_hits++;
        check($sformatf("t5_done_at_%0d", c), 32'(c), 32'(done_hits * 10 - 1));
        check("t5_count", 32'(a_if.out_unsat_count), 3);
      end
    end
    check("t5_done_hits", 32'(done_hits), 3);
    start_a = 1'b0;
    done_hits = 0;
    for (int c = 0; c < 12 && done_hits == 0; c++) begin
      @(negedge clk);
      if (a_if.out_done) done_hits++;
    end
    check("t5_drain_done", 32'(done_hits), 1);
    check("t5_drain_count", 32'(a_if.out_unsat_count), 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
